// File: rtl/taus_pkg.sv
// rtl/taus_pkg.sv - Tausworthe generator constants, scheduler states and step function
package taus_pkg;

   localparam logic [31:0] SEED_DEF     = 32'hffffffff;
   localparam int          SHIFT_L1_DEF = 13;
   localparam int          SHIFT_R_DEF  = 19;
   localparam int          SHIFT_L2_DEF = 12;
   localparam logic [31:0] CONST_DEF    = 32'hfffffffe;

   typedef enum logic {WARM, RUN} taus_state_e;

   function automatic logic [31:0] taus_next(
      input logic [31:0] s,
      input int          l1 = SHIFT_L1_DEF,
      input int          r  = SHIFT_R_DEF,
      input int          l2 = SHIFT_L2_DEF,
      input logic [31:0] c  = CONST_DEF
   );
      return (((s << l1) ^ s) >> r) ^ ((s & c) << l2);
   endfunction

endpackage

// File: rtl/taus_rr_arb.sv
// rtl/taus_rr_arb.sv - combinational round-robin picker, search starts just above ptr
module taus_rr_arb #(
   parameter int N_REQ = 4,
   parameter int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IW-1:0]    ptr_i,
   output logic [N_REQ-1:0] gnt_nxt_o,
   output logic [IW-1:0]    idx_o
);

   always_comb begin
      int   j;
      logic found;
      gnt_nxt_o = '0;
      idx_o     = '0;
      found     = 1'b0;
      j         = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         j = (int'(ptr_i) + k) % N_REQ;
         if (!found && req_i[IW'(j)]) begin
            found             = 1'b1;
            gnt_nxt_o[IW'(j)] = 1'b1;
            idx_o             = IW'(j);
         end
      end
   end

endmodule

// File: rtl/taus_rr_sched.sv
// rtl/taus_rr_sched.sv - round-robin sharing of one Tausworthe generator; optional TAUS_GRANT_CNT_EN
module taus_rr_sched
   import taus_pkg::*;
#(
   parameter int          N_REQ    = 4,
   parameter int          WARMUP   = 16,
   parameter logic [31:0] SEED     = SEED_DEF,
   parameter int          SHIFT_L1 = SHIFT_L1_DEF,
   parameter int          SHIFT_R  = SHIFT_R_DEF,
   parameter int          SHIFT_L2 = SHIFT_L2_DEF,
   parameter logic [31:0] CONST    = CONST_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     seed_load,
   input  logic [31:0]              seed_val,
   input  logic [N_REQ-1:0]         req,
   output logic [N_REQ-1:0]         gnt,
   output logic                     rnd_valid,
   output logic [31:0]              rnd_data,
   output logic [$clog2(N_REQ)-1:0] rnd_id,
   output logic                     ready
`ifdef TAUS_GRANT_CNT_EN
   ,
   output logic [15:0]              grant_cnt
`endif
);

   localparam int          IW       = $clog2(N_REQ);
   localparam logic [7:0]  WARMUP_C = 8'(WARMUP);

   taus_state_e      state_q;
   logic [31:0]      s_q, s_step, seed_d, rnd_data_q;
   logic [7:0]       warm_cnt_q;
   logic [IW-1:0]    ptr_q, arb_idx, rnd_id_q;
   logic [N_REQ-1:0] arb_gnt, gnt_q;
   logic             grant_go;

   taus_rr_arb #(.N_REQ(N_REQ), .IW(IW)) u_arb (
      .req_i     (req),
      .ptr_i     (ptr_q),
      .gnt_nxt_o (arb_gnt),
      .idx_o     (arb_idx)
   );

   assign s_step   = taus_next(s_q, SHIFT_L1, SHIFT_R, SHIFT_L2, CONST);
   // All-zero and lone-LSB seeds lock the generator up, so they fall back to SEED.
   assign seed_d   = (seed_val[31:1] == 31'd0) ? SEED : seed_val;
   assign grant_go = (state_q == RUN) && (|req) && !seed_load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= WARM;
         s_q        <= SEED;
         warm_cnt_q <= '0;
         ptr_q      <= IW'(N_REQ - 1);
         gnt_q      <= '0;
         rnd_data_q <= '0;
         rnd_id_q   <= '0;
      end else begin
         gnt_q <= '0;
         if (seed_load) begin
            s_q        <= seed_d;
            warm_cnt_q <= '0;
            state_q    <= WARM;
         end else begin
            case (state_q)
               WARM: begin
                  if (warm_cnt_q == WARMUP_C) begin
                     state_q <= RUN;
                  end else begin
                     s_q        <= s_step;
                     warm_cnt_q <= warm_cnt_q + 8'd1;
                  end
               end
               RUN: begin
                  if (grant_go) begin
                     gnt_q      <= arb_gnt;
                     rnd_id_q   <= arb_idx;
                     rnd_data_q <= s_step;
                     s_q        <= s_step;
                     ptr_q      <= arb_idx;
                  end
               end
               default: state_q <= WARM;
            endcase
         end
      end
   end

   assign gnt       = gnt_q;
   assign rnd_valid = |gnt_q;
   assign rnd_data  = rnd_data_q;
   assign rnd_id    = rnd_id_q;
   assign ready     = (state_q == RUN);

`ifdef TAUS_GRANT_CNT_EN
   logic [15:0] grant_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt_q <= '0;
      end else if (seed_load) begin
         grant_cnt_q <= '0;
      end else if (grant_go && grant_cnt_q != 16'hffff) begin
         grant_cnt_q <= grant_cnt_q + 16'd1;
      end
   end

   assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: doc/taus_rr_sched.md
Name: taus_rr_sched

Overview:
- Round-robin scheduler that shares one 32-bit Tausworthe generator among N_REQ requesters.
- Sequences the generator: seeds it, runs a discard (warm-up) phase, then hands one random word per grant.
- Sits between the generator step logic and consumer blocks such as noise injectors and test-pattern sources.
- Provides reseed on demand without a global reset.

Parameters:
- N_REQ, 4: number of requesters; legal range 2..16.
- WARMUP, 16: number of generator steps discarded after reset or reseed; legal range 0..255.
- SEED, 32'hffffffff: reset seed; also replaces any degenerate seed_val.
- SHIFT_L1, 13: first left shift.
- SHIFT_R, 19: right shift.
- SHIFT_L2, 12: second left shift.
- CONST, 32'hfffffffe: mask constant.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- seed_load  in  1  one-cycle pulse; load seed_val and restart warm-up.
- seed_val  in  32  new seed.
- req  in  N_REQ  level request, one bit per requester.
- gnt  out  N_REQ  one-hot grant, registered.
- rnd_valid  out  1  rnd_data/rnd_id valid this cycle; equals |gnt.
- rnd_data  out  32  random word delivered with the grant.
- rnd_id  out  $clog2(N_REQ)  index of the granted requester.
- ready  out  1  1 in RUN state.

Behaviour:
- Generator step, combinational: nxt = (((s << SHIFT_L1) ^ s) >> SHIFT_R) ^ ((s & CONST) << SHIFT_L2). All operations are 32-bit and overflow bits are dropped. The state s advances to nxt only when stepped.
- Reset (rst_n=0, asynchronous):
  - s=SEED, state=WARM, warm_cnt=0, last grant pointer = N_REQ-1.
  - gnt=0, rnd_valid=0, rnd_data=0, rnd_id=0, ready=0.
- States: WARM, RUN.
- WARM:
  - Step s every cycle and increment warm_cnt.
  - When warm_cnt reaches WARMUP, go to RUN on the next edge.
  - With WARMUP=0, go to RUN on the first edge after reset and do not step.
  - gnt=0 and req is ignored.
- RUN, arbitration:
  - Each cycle, if any req bit is set, select the first set bit searching from (ptr+1) mod N_REQ upward, with wrap-around.
  - On the next edge, register the one-hot gnt, rnd_id=index, rnd_valid=1, rnd_data=nxt. Also set s=nxt and ptr=index.
- RUN, timing and idle:
  - Latency from req sampled to gnt/rnd_data is 1 cycle.
  - One word is consumed per grant.
  - A requester that holds req high receives grants interleaved fairly with the others.
  - If req=0, then gnt=0, rnd_valid=0, rnd_data holds its last value, and s is not stepped.
- seed_load, in any state:
  - On the next edge: s = (seed_val[31:1]==0) ? SEED : seed_val; warm_cnt=0; state=WARM; gnt=0; rnd_valid=0.
  - ptr is unchanged.
  - seed_load overrides a simultaneous grant; that request is not served and must stay asserted.
- seed_load during WARM restarts the warm-up count.
- A requester dropping req while granted has no effect; grants are single-cycle.

Optional Feature:
- Macro TAUS_GRANT_CNT_EN.
- When defined:
  - Extra output port grant_cnt [15:0].
  - Increments on every rnd_valid=1 cycle and saturates at 16'hffff.
  - Cleared by rst_n and by seed_load.
- When undefined: no port and no counter logic. All other behaviour is identical.

Decomposition:
- Package taus_pkg holds:
  - default constants: SEED, shift amounts, CONST;
  - state enum {WARM, RUN};
  - function taus_next(s) implementing the step equation.
- Sub-module taus_rr_arb: pure combinational round-robin picker with inputs req and ptr, outputs one-hot gnt_nxt and idx.

Test Plan:
- Default reset, WARMUP=0, req=4'b0001 held: first rnd_data=32'hffffe000 with gnt=0001 and rnd_id=0, one cycle after rst_n release plus one cycle.
- req=4'b1111 held in RUN: gnt sequence 0001,0010,0100,1000,0001, and each rnd_data equals taus_next of the previous word.
- seed_val=32'h00000001 with seed_load: s loads SEED (degenerate seed replaced); ready drops for WARMUP cycles; next word is identical to the post-reset sequence.
- WARMUP=16, req held from reset: ready=0 and gnt=0 for 16 cycles; first grant delivers the 17th step from SEED.
- seed_load in the same cycle as req=4'b0100 in RUN: no grant that cycle, ready=0; the grant to requester 2 arrives after warm-up.
- rst_n asserted mid-RUN with gnt active: gnt, rnd_valid and ready go to 0 immediately (asynchronously); s=SEED.
